// File: rtl/ps2_ctl_pkg.sv
// Shared types and constants for the PS/2 send scheduler.
package ps2_ctl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_BUSY,
    ST_WAIT_DONE,
    ST_GAP
  } state_t;

  // One queued byte: the end-of-packet flag travels with the data.
  typedef struct packed {
    logic       last;
    logic [7:0] data;
  } fifo_entry_t;

  localparam logic SRC_KBD  = 1'b0;
  localparam logic SRC_HOST = 1'b1;

endpackage

// File: rtl/ps2_byte_fifo.sv
// Show-ahead byte FIFO: the oldest entry is always visible on head.
module ps2_byte_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 9
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == PW'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr[AW-1:0]];

  // Pointers and occupancy; a push and pop in the same cycle leave count unchanged.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + PW'(1);
        2'b01:   count <= count - PW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents need no reset because empty masks stale entries.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/ps2_send_ctl.sv
// Two-source scheduler in front of the PS/2 byte transmitter: fixed priority
// to source 0, packets never interleaved, gap after each packet and timeout.
module ps2_send_ctl
  import ps2_ctl_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int GAP   = 2500,
  parameter int TMO   = 64
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       s0_valid,
  input  logic [7:0] s0_data,
  input  logic       s0_last,
  output logic       s0_ready,
  input  logic       s1_valid,
  input  logic [7:0] s1_data,
  input  logic       s1_last,
  output logic       s1_ready,
  output logic       tx_send,
  output logic [7:0] tx_code,
  input  logic       tx_busy,
  input  logic       tx_rdy,
  output logic       active_src,
  output logic       err_timeout
);

  localparam bit          HAS_GAP  = (GAP > 0);
  localparam logic [15:0] GAP_LOAD = (GAP > 0) ? 16'(GAP - 1) : 16'd0;
  localparam logic [15:0] TMO_LOAD = (TMO > 0) ? 16'(TMO - 1) : 16'd0;

  state_t      state;
  state_t      next_state;
  fifo_entry_t s0_entry;
  fifo_entry_t s1_entry;
  fifo_entry_t head0;
  fifo_entry_t head1;
  fifo_entry_t grant_head;
  logic        full0, empty0, full1, empty1;
  logic        push0, push1, pop0, pop1;
  logic        grant_valid;
  logic        grant_src;
  logic        lock;
  logic        cur_last;
  logic        timeout_hit;
  logic [15:0] gap_cnt;
  logic [15:0] tmo_cnt;

  assign s0_entry = '{last: s0_last, data: s0_data};
  assign s1_entry = '{last: s1_last, data: s1_data};
  assign s0_ready = !full0;
  assign s1_ready = !full1;
  assign push0    = s0_valid && s0_ready;
  assign push1    = s1_valid && s1_ready;

  ps2_byte_fifo #(.DEPTH(DEPTH), .WIDTH(9)) u_fifo0 (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push0),
    .pop     (pop0),
    .din     (s0_entry),
    .full    (full0),
    .empty   (empty0),
    .head    (head0)
  );

  ps2_byte_fifo #(.DEPTH(DEPTH), .WIDTH(9)) u_fifo1 (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push1),
    .pop     (pop1),
    .din     (s1_entry),
    .full    (full1),
    .empty   (empty1),
    .head    (head1)
  );

  assign timeout_hit = (state == ST_WAIT_BUSY) && !tx_busy && (tmo_cnt == 16'd0);
  assign grant_head  = (grant_src == SRC_KBD) ? head0 : head1;

  // Arbiter: a held lock pins the current source, otherwise source 0 first.
  always_comb begin
    grant_valid = 1'b0;
    grant_src   = SRC_KBD;
    if (lock) begin
      grant_src   = active_src;
      grant_valid = (active_src == SRC_KBD) ? !empty0 : !empty1;
    end else if (!empty0) begin
      grant_valid = 1'b1;
      grant_src   = SRC_KBD;
    end else if (!empty1) begin
      grant_valid = 1'b1;
      grant_src   = SRC_HOST;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= next_state;
  end

  // Next-state logic; a dropped byte after timeout still earns the gap.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:      if (grant_valid && tx_rdy) next_state = ST_ISSUE;
      ST_ISSUE:     next_state = ST_WAIT_BUSY;
      ST_WAIT_BUSY: begin
        if (tx_busy)          next_state = ST_WAIT_DONE;
        else if (timeout_hit) next_state = HAS_GAP ? ST_GAP : ST_IDLE;
      end
      ST_WAIT_DONE: begin
        if (tx_rdy) begin
          if (cur_last) next_state = HAS_GAP ? ST_GAP : ST_IDLE;
          else          next_state = ST_IDLE;
        end
      end
      ST_GAP:       if (gap_cnt == 16'd0) next_state = ST_IDLE;
      default:      next_state = ST_IDLE;
    endcase
  end

  // Decoded outputs: the send pulse and FIFO pop both coincide with ISSUE.
  always_comb begin
    tx_send     = (state == ST_ISSUE);
    pop0        = (state == ST_ISSUE) && (active_src == SRC_KBD);
    pop1        = (state == ST_ISSUE) && (active_src == SRC_HOST);
    err_timeout = timeout_hit;
  end

  // Byte capture on grant and packet lock bookkeeping; tx_code holds until the next grant.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_code    <= 8'h00;
      active_src <= SRC_KBD;
      cur_last   <= 1'b0;
      lock       <= 1'b0;
    end else begin
      if (state == ST_IDLE && next_state == ST_ISSUE) begin
        tx_code    <= grant_head.data;
        active_src <= grant_src;
        cur_last   <= grant_head.last;
      end
      if (timeout_hit)                          lock <= 1'b0;
      else if (state == ST_WAIT_DONE && tx_rdy) lock <= !cur_last;
    end
  end

  // Down-counters for the busy timeout and the inter-packet gap, both stopping at zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmo_cnt <= 16'd0;
      gap_cnt <= 16'd0;
    end else begin
      if (state == ST_ISSUE)
        tmo_cnt <= TMO_LOAD;
      else if (state == ST_WAIT_BUSY && tmo_cnt != 16'd0)
        tmo_cnt <= tmo_cnt - 16'd1;

      if (next_state == ST_GAP && state != ST_GAP)
        gap_cnt <= GAP_LOAD;
      else if (state == ST_GAP && gap_cnt != 16'd0)
        gap_cnt <= gap_cnt - 16'd1;
    end
  end

endmodule

// File: tb/tb_ps2_send_ctl.sv
// Self-checking bench for ps2_send_ctl with a behavioural transmitter and
// per-source byte queues that model delivery order and packet atomicity.
module tb_ps2_send_ctl;

  localparam int DEPTH    = 4;
  localparam int GAP      = 20;
  localparam int TMO      = 16;
  localparam int BUSY_LEN = 22;

  typedef struct {
    logic [7:0] data;
    bit         last;
  } byte_t;

  typedef struct {
    bit         src;
    logic [7:0] data;
    bit         last;
    logic [7:0] exp_code;
    bit         exp_src;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       s0_valid = 1'b0, s1_valid = 1'b0;
  logic [7:0] s0_data = 8'h00, s1_data = 8'h00;
  logic       s0_last = 1'b0, s1_last = 1'b0;
  logic       s0_ready, s1_ready;
  logic       tx_send;
  logic [7:0] tx_code;
  logic       tx_busy = 1'b0;
  logic       tx_rdy = 1'b1;
  logic       active_src;
  logic       err_timeout;

  int    cyc = 0;
  int    tests_run = 0;
  int    failed = 0;
  int    sends = 0;
  int    errs = 0;
  int    last_send_cyc = 0;
  int    last_err_cyc = 0;
  int    busy_cnt = 0;
  bit    tx_dead = 1'b0;
  bit    tx_hold = 1'b0;
  bit    lock_pending = 1'b0;
  bit    lock_src = 1'b0;
  bit    mon_have;
  byte_t mon_e;
  byte_t q0[$];
  byte_t q1[$];
  vec_t  vecs[4];

  ps2_send_ctl #(.DEPTH(DEPTH), .GAP(GAP), .TMO(TMO)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .s0_valid    (s0_valid),
    .s0_data     (s0_data),
    .s0_last     (s0_last),
    .s0_ready    (s0_ready),
    .s1_valid    (s1_valid),
    .s1_data     (s1_data),
    .s1_last     (s1_last),
    .s1_ready    (s1_ready),
    .tx_send     (tx_send),
    .tx_code     (tx_code),
    .tx_busy     (tx_busy),
    .tx_rdy      (tx_rdy),
    .active_src  (active_src),
    .err_timeout (err_timeout)
  );

  // Free-running clock and cycle counter.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input int actual, input int expected);
    tests_run++;
    if (actual !== expected) begin
      failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Monitor and transmitter model: every send must be the oldest byte of its
  // source, a packet in progress must not be interrupted, and the transmitter
  // goes busy for BUSY_LEN cycles per send unless told to stay dead.
  always @(negedge clk) begin
    if (!reset_n) begin
      busy_cnt     = 0;
      lock_pending = 1'b0;
    end else begin
      if (tx_send) begin
        sends++;
        last_send_cyc = cyc;
        if (lock_pending) check_output("packet_src", int'(active_src), int'(lock_src));
        mon_have = (active_src == 1'b0) ? (q0.size() > 0) : (q1.size() > 0);
        check_output("queued_byte_exists", int'(mon_have), 1);
        if (mon_have) begin
          if (active_src == 1'b0) mon_e = q0.pop_front();
          else                    mon_e = q1.pop_front();
          check_output("byte_order", int'(tx_code), int'(mon_e.data));
          lock_pending = !mon_e.last;
          lock_src     = active_src;
        end
      end
      if (err_timeout) begin
        errs++;
        last_err_cyc = cyc;
        lock_pending = 1'b0;
      end
      if (tx_send && !tx_dead) busy_cnt = BUSY_LEN;
      else if (busy_cnt > 0)   busy_cnt--;
    end
    tx_busy = (busy_cnt != 0);
    tx_rdy  = !tx_busy && !tx_hold;
  end

  // Offer one byte on a source, hold it until accepted, record acceptance cycle.
  task automatic apply_stimulus(input bit src, input logic [7:0] d, input bit l, output int acc);
    int    guard = 0;
    byte_t e;
    e.data = d;
    e.last = l;
    acc    = -1;
    @(negedge clk);
    if (src == 1'b0) begin s0_valid = 1'b1; s0_data = d; s0_last = l; end
    else             begin s1_valid = 1'b1; s1_data = d; s1_last = l; end
    while (((src == 1'b0) ? s0_ready : s1_ready) == 1'b0 && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    check_output("push_accept", int'(guard < 2000), 1);
    if (guard < 2000) begin
      @(posedge clk);
      if (src == 1'b0) q0.push_back(e);
      else             q1.push_back(e);
      #1 acc = cyc;
    end
    if (src == 1'b0) s0_valid = 1'b0;
    else             s1_valid = 1'b0;
  endtask

  task automatic wait_send(input int prev, output int scyc);
    int guard = 0;
    while (sends <= prev && guard < 5000) begin
      @(posedge clk);
      guard++;
    end
    check_output("send_seen", int'(sends > prev), 1);
    scyc = last_send_cyc;
    @(negedge clk);
  endtask

  task automatic wait_err(input int prev, output int ecyc);
    int guard = 0;
    while (errs <= prev && guard < 5000) begin
      @(posedge clk);
      guard++;
    end
    check_output("timeout_seen", int'(errs > prev), 1);
    ecyc = last_err_cyc;
    @(negedge clk);
  endtask

  task automatic drain();
    int guard = 0;
    while ((q0.size() + q1.size()) != 0 && guard < 20000) begin
      @(posedge clk);
      guard++;
    end
    check_output("drain_empty", q0.size() + q1.size(), 0);
    repeat (BUSY_LEN + GAP + 8) @(posedge clk);
  endtask

  task automatic random_source(input bit src, input int n);
    int acc;
    bit l;
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(0, 6)) @(negedge clk);
      l = (k == n - 1) ? 1'b1 : ($urandom_range(0, 2) != 0);
      apply_stimulus(src, 8'($urandom_range(0, 255)), l, acc);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check_output({tag, "_tx_send"}, int'(tx_send), 0);
    check_output({tag, "_tx_code"}, int'(tx_code), 0);
    check_output({tag, "_active_src"}, int'(active_src), 0);
    check_output({tag, "_err_timeout"}, int'(err_timeout), 0);
    check_output({tag, "_s0_ready"}, int'(s0_ready), 1);
    check_output({tag, "_s1_ready"}, int'(s1_ready), 1);
  endtask

  // Watchdog so the bench always terminates.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int prev, prev_e, acc, acc5, scyc, scyc2, ecyc;

    vecs[0] = '{src: 1'b0, data: 8'h1C, last: 1'b1, exp_code: 8'h1C, exp_src: 1'b0};
    vecs[1] = '{src: 1'b1, data: 8'hFA, last: 1'b1, exp_code: 8'hFA, exp_src: 1'b1};
    vecs[2] = '{src: 1'b0, data: 8'h00, last: 1'b1, exp_code: 8'h00, exp_src: 1'b0};
    vecs[3] = '{src: 1'b1, data: 8'hFF, last: 1'b1, exp_code: 8'hFF, exp_src: 1'b1};

    // Reset state
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    reset_n = 1'b1;

    // Single bytes from an idle controller: one-cycle latency from enqueue
    for (int i = 0; i < 4; i++) begin
      prev = sends;
      apply_stimulus(vecs[i].src, vecs[i].data, vecs[i].last, acc);
      wait_send(prev, scyc);
      check_output("vec_latency", scyc - acc, 1);
      check_output("vec_code", int'(tx_code), int'(vecs[i].exp_code));
      check_output("vec_src", int'(active_src), int'(vecs[i].exp_src));
      check_output("vec_pulse_width", int'(tx_send), 0);
      drain();
    end

    // Send-to-send spacing: busy window, one cycle to see ready, GAP, one idle cycle
    prev = sends;
    apply_stimulus(1'b0, 8'h1C, 1'b1, acc);
    wait_send(prev, scyc);
    apply_stimulus(1'b0, 8'h5A, 1'b1, acc);
    wait_send(prev + 1, scyc2);
    check_output("gap_spacing", scyc2 - scyc, BUSY_LEN + GAP + 2);
    check_output("gap_second_code", int'(tx_code), 8'h5A);
    drain();

    // Both sources offer in the same cycle: source 0 first
    prev = sends;
    fork
      apply_stimulus(1'b0, 8'h29, 1'b1, acc);
      apply_stimulus(1'b1, 8'hFA, 1'b1, acc5);
    join
    wait_send(prev, scyc);
    check_output("prio_first_code", int'(tx_code), 8'h29);
    check_output("prio_first_src", int'(active_src), 0);
    wait_send(prev + 1, scyc);
    check_output("prio_second_code", int'(tx_code), 8'hFA);
    check_output("prio_second_src", int'(active_src), 1);
    drain();

    // Multi-byte packet on source 1 is not interrupted by source 0
    prev = sends;
    apply_stimulus(1'b1, 8'hE0, 1'b0, acc);
    apply_stimulus(1'b1, 8'h75, 1'b1, acc);
    wait_send(prev, scyc);
    check_output("lock_first_code", int'(tx_code), 8'hE0);
    apply_stimulus(1'b0, 8'h1C, 1'b1, acc);
    wait_send(prev + 1, scyc);
    check_output("lock_second_code", int'(tx_code), 8'h75);
    check_output("lock_second_src", int'(active_src), 1);
    wait_send(prev + 2, scyc);
    check_output("lock_third_code", int'(tx_code), 8'h1C);
    check_output("lock_third_src", int'(active_src), 0);
    drain();

    // FIFO full with the transmitter stalled
    tx_hold = 1'b1;
    apply_stimulus(1'b0, 8'hAA, 1'b1, acc);
    apply_stimulus(1'b0, 8'hBB, 1'b1, acc);
    apply_stimulus(1'b0, 8'hCC, 1'b1, acc);
    apply_stimulus(1'b0, 8'hDD, 1'b1, acc);
    @(negedge clk);
    check_output("full_ready_low", int'(s0_ready), 0);
    prev = sends;
    fork
      apply_stimulus(1'b0, 8'hEE, 1'b1, acc5);
      begin
        repeat (5) @(negedge clk);
        check_output("full_still_blocked", int'(s0_ready), 0);
        tx_hold = 1'b0;
        wait_send(prev, scyc);
      end
    join
    check_output("full_first_code", int'(tx_code), 8'hAA);
    check_output("full_fifth_accept", acc5 - scyc, 2);
    drain();

    // Transmitter never goes busy: timeout, lock released, next byte after gap
    tx_dead = 1'b1;
    prev    = sends;
    prev_e  = errs;
    fork
      apply_stimulus(1'b0, 8'h11, 1'b0, acc);
      apply_stimulus(1'b1, 8'h44, 1'b1, acc5);
    join
    wait_send(prev, scyc);
    check_output("tmo_first_code", int'(tx_code), 8'h11);
    wait_err(prev_e, ecyc);
    check_output("tmo_delay", ecyc - scyc, TMO);
    check_output("tmo_pulse_width", int'(err_timeout), 0);
    tx_dead = 1'b0;
    wait_send(prev + 1, scyc2);
    check_output("tmo_next_code", int'(tx_code), 8'h44);
    check_output("tmo_next_src", int'(active_src), 1);
    check_output("tmo_next_spacing", scyc2 - ecyc, GAP + 2);
    drain();

    // Reset while a byte is in flight and three more are queued
    prev = sends;
    apply_stimulus(1'b0, 8'hA1, 1'b1, acc);
    apply_stimulus(1'b0, 8'hA2, 1'b1, acc);
    apply_stimulus(1'b0, 8'hA3, 1'b1, acc);
    apply_stimulus(1'b1, 8'hB1, 1'b1, acc);
    wait_send(prev, scyc);
    check_output("rst_sent_code", int'(tx_code), 8'hA1);
    repeat (4) @(negedge clk);
    #2 reset_n = 1'b0;
    #1 check_reset_values("midrst");
    q0.delete();
    q1.delete();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    prev = sends;
    repeat (60) @(negedge clk);
    check_output("flush_no_send", sends - prev, 0);
    check_output("flush_s0_ready", int'(s0_ready), 1);

    // Randomised traffic from both sources against the queue model
    prev = sends;
    fork
      random_source(1'b0, 25);
      random_source(1'b1, 25);
    join
    drain();
    check_output("random_total_sends", sends - prev, 50);

    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
